header_parser: RTL and testbench

HEADER_PARSER -- requirements
Module: header_parser

---
 rtl/header_parser.sv | 71 +++++++
 tb/tb_header_parser.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/header_parser.sv
// header_parser: forwards packet words with a 1-cycle delay, tagging each with its
// Ethernet frame word index and whether it carries UDP payload.
module header_parser #(
  parameter int DWIDTH     = 64,
  parameter int CTRL_WIDTH = DWIDTH / 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DWIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [15:0]           data_count,
  output logic                  o_inside_payload
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d, cnt_inc;
  logic                    pay_q, pay_d, wr_q, xfer, eop;
  logic [DWIDTH-1:0]       data_q;
  logic [CTRL_WIDTH-1:0]   ctrl_q;
  assign in_rdy           = out_rdy;
  assign xfer             = in_wr & out_rdy;
  assign eop              = |in_ctrl;
  assign out_data         = data_q;
  assign out_ctrl         = ctrl_q;
  assign out_wr           = wr_q;
  assign data_count       = cnt_q;
  assign o_inside_payload = pay_q;
  // The count register doubles as the output tag, so it freezes whenever nothing transfers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    if (xfer) begin
      if (state_q == IDLE) begin
        cnt_d   = '0;
        pay_d   = 1'b0;
        state_d = eop ? IDLE : HDR;
      end else begin
        cnt_d   = cnt_inc;
        pay_d   = eop ? (state_q == PAYLOAD) : (cnt_inc >= 16'd5);
        state_d = eop ? IDLE : ((cnt_inc >= 16'd5) ? PAYLOAD : HDR);
      end
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pay_q   <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
      wr_q    <= xfer;
      if (xfer) begin
        data_q <= in_data;
        ctrl_q <= in_ctrl;
      end
    end
  end
endmodule

// File: tb/tb_header_parser.sv
// tb_header_parser: directed stimulus with a scoreboard of expected words, tags and flags.
module tb_header_parser;
  logic        i_clock = 1'b0, i_reset, in_wr, in_rdy, out_wr, out_rdy, o_inside_payload;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [15:0] data_count;
  typedef struct {logic [63:0] d; logic [7:0] c; logic [15:0] n; logic p;} exp_t;
  exp_t        q[$];
  int          passed = 0, total = 0, n_push = 0, n_out = 0;
  int          m_st = 0;
  logic        m_payst = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [15:0] last_cnt = '0;
  logic        last_pay = 1'b0;

  header_parser #(.DWIDTH(64), .CTRL_WIDTH(8)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_wr(in_wr), .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_rdy(out_rdy), .data_count(data_count),
    .o_inside_payload(o_inside_payload)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge i_clock) begin
    if (out_wr === 1'b1) begin
      exp_t e;
      n_out++;
      if (q.size() == 0) chk("unexpected_word", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ctrl", {56'd0, out_ctrl}, {56'd0, e.c});
        chk("data_count", {48'd0, data_count}, {48'd0, e.n});
        chk("payload", {63'd0, o_inside_payload}, {63'd0, e.p});
        last_cnt = data_count;
        last_pay = o_inside_payload;
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [7:0] c);
    exp_t e;
    in_data = d;
    in_ctrl = c;
    in_wr   = 1'b1;
    if (out_rdy && !i_reset) begin
      if (m_st == 0) begin
        e.n = '0; e.p = 1'b0; m_payst = 1'b0;
        m_st = (c == 0) ? 1 : 0;
      end else begin
        e.n = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        if (c != 0) begin
          e.p = m_payst; m_st = 0;
        end else begin
          e.p = (e.n >= 16'd5); m_payst = e.p;
        end
      end
      m_cnt = e.n; e.d = d; e.c = c;
      q.push_back(e);
      n_push++;
    end
    @(posedge i_clock); #1;
  endtask

  task automatic idle(input int n);
    in_wr = 1'b0;
    repeat (n) begin @(posedge i_clock); #1; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, {63'd0, out_wr}, 64'd0);
    chk({tag, "_data"}, out_data, 64'd0);
    chk({tag, "_ctrl"}, {56'd0, out_ctrl}, 64'd0);
    chk({tag, "_cnt"}, {48'd0, data_count}, 64'd0);
    chk({tag, "_pay"}, {63'd0, o_inside_payload}, 64'd0);
  endtask

  initial begin
    i_reset = 1'b1; in_wr = 1'b0; out_rdy = 1'b1; in_data = '0; in_ctrl = '0;
    repeat (2) begin @(posedge i_clock); #1; end
    chk_zero("reset");
    out_rdy = 1'b0; #1;
    chk("in_rdy_in_reset", {63'd0, in_rdy}, 64'd0);
    out_rdy = 1'b1; #1;
    i_reset = 1'b0;
    // Basic packet: header, nine frame words, EOP.
    send(64'hAAAA_0000_0000_00FF, 8'hFF);
    for (int i = 0; i < 9; i++) send(64'h1000 + 64'(i), 8'h00);
    send(64'hE0E0_E0E0, 8'h01);
    idle(2);
    chk("eop_count", {48'd0, last_cnt}, 64'd9);
    chk("eop_payload", {63'd0, last_pay}, 64'd1);
    // Stall with frame word 3 pending.
    send(64'hBB, 8'hFF);
    for (int i = 0; i < 3; i++) send(64'h2000 + 64'(i), 8'h00);
    in_data = 64'h2003; in_ctrl = 8'h00; in_wr = 1'b1; out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clock); #1;
      chk("stall_in_rdy", {63'd0, in_rdy}, 64'd0);
      chk("stall_out_wr", {63'd0, out_wr}, 64'd0);
    end
    out_rdy = 1'b1;
    send(64'h2003, 8'h00);
    chk("resume_wr", {63'd0, out_wr}, 64'd1);
    chk("resume_cnt", {48'd0, data_count}, 64'd3);
    for (int i = 4; i < 7; i++) send(64'h2000 + 64'(i), 8'h00);
    send(64'hE1, 8'h02);
    // Back-to-back packets with no gap.
    send(64'hCC, 8'hFF);
    for (int i = 0; i < 6; i++) send(64'h3000 + 64'(i), 8'h00);
    send(64'hE2, 8'h01);
    send(64'hDD, 8'hFF);
    send(64'h4000, 8'h00);
    chk("b2b_cnt", {48'd0, data_count}, 64'd0);
    chk("b2b_pay", {63'd0, o_inside_payload}, 64'd0);
    for (int i = 1; i < 6; i++) send(64'h4000 + 64'(i), 8'h00);
    send(64'hE3, 8'h01);
    // Reset at frame word 6.
    send(64'hEE, 8'hFF);
    for (int i = 0; i < 6; i++) send(64'h5000 + 64'(i), 8'h00);
    i_reset = 1'b1;
    send(64'h5006, 8'h00);
    chk_zero("midreset");
    i_reset = 1'b0; m_st = 0; m_cnt = '0;
    send(64'h6000, 8'h00);
    chk("post_reset_cnt", {48'd0, data_count}, 64'd0);
    for (int i = 1; i < 7; i++) send(64'h6000 + 64'(i), 8'h00);
    send(64'hE4, 8'h01);
    idle(1);
    chk("post_reset_eop_cnt", {48'd0, last_cnt}, 64'd7);
    // 64-word stream.
    send(64'hFF, 8'hFF);
    for (int i = 0; i < 62; i++) send({$urandom, $urandom}, 8'h00);
    send(64'hE5, 8'h01);
    idle(3);
    chk("stream_last_cnt", {48'd0, last_cnt}, 64'd62);
    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("word_count", 64'(n_out), 64'(n_push));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
